// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the SRAM arbiter
package mem_arbiter_pkg;

  localparam int SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    LS_WORD = 1'b0,
    LS_BYTE = 1'b1
  } ls_width_t;

  // SRAM is word organised: byte address bits [21:2] select the word
  function automatic logic [SRAM_ADDR_W-1:0] word_addr(input logic [21:0] a);
    return a[21:2];
  endfunction

endpackage

// File: rtl/sram_byte_lane.sv
// rtl/sram_byte_lane.sv - byte enables, store replication and load extraction
module sram_byte_lane
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  ls_width_t   i_width,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be_n,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0] w_byte;

  // word accesses use every lane; byte accesses enable one lane and sign-extend loads
  always_comb begin
    w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
    o_be_n  = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    if (i_width == LS_BYTE) begin
      o_be_n  = ~(4'b0001 << i_addr_lo);
      o_wdata = {4{i_wdata[7:0]}};
      o_rdata = {{24{w_byte[7]}}, w_byte};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single asynchronous SRAM port
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic                   if_ack,
  output logic [31:0]            if_rdata,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic                   mem_byte,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  output logic                   mem_ack,
  output logic [31:0]            mem_rdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata,
  output logic                   sram_oe_data,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [3:0]             sram_be_n,
  output logic                   busy
);

  arb_state_t  r_state;
  logic        r_starve;
  logic        r_is_if;
  logic        r_we;
  ls_width_t   r_width;
  logic [21:0] r_addr;

  logic        w_grant_if;
  logic [31:0] w_sel_addr;
  logic        w_sel_we;
  ls_width_t   w_sel_width;
  logic [31:0] w_sel_wdata;
  logic [1:0]  w_lane_addr;
  ls_width_t   w_lane_width;
  logic [3:0]  w_lane_be_n;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic        w_unused;

  // data side wins unless the fetch already lost the previous grant
  assign w_grant_if  = if_req && (!mem_req || r_starve);
  assign w_sel_addr  = w_grant_if ? if_addr : mem_addr;
  assign w_sel_we    = w_grant_if ? 1'b0 : mem_we;
  assign w_sel_width = (!w_grant_if && mem_byte) ? LS_BYTE : LS_WORD;
  assign w_sel_wdata = w_grant_if ? 32'h0 : mem_wdata;

  // in IDLE the lane logic sees the request being granted, afterwards the latched one
  assign w_lane_addr  = (r_state == ST_IDLE) ? w_sel_addr[1:0] : r_addr[1:0];
  assign w_lane_width = (r_state == ST_IDLE) ? w_sel_width : r_width;

  assign w_unused = ^{if_addr[31:22], mem_addr[31:22]};

  sram_byte_lane u_lane (
    .i_addr_lo (w_lane_addr),
    .i_width   (w_lane_width),
    .i_wdata   (w_sel_wdata),
    .i_rdata   (sram_rdata),
    .o_be_n    (w_lane_be_n),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

  // arbitration FSM with all SRAM strobes, acks and read data registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve     <= 1'b0;
      r_is_if      <= 1'b0;
      r_we         <= 1'b0;
      r_width      <= LS_WORD;
      r_addr       <= '0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_oe_data <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'b1111;
      if_ack       <= 1'b0;
      mem_ack      <= 1'b0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (if_req || mem_req) begin
            r_state    <= ST_SETUP;
            busy       <= 1'b1;
            r_is_if    <= w_grant_if;
            r_starve   <= !w_grant_if && if_req;
            r_addr     <= w_sel_addr[21:0];
            r_we       <= w_sel_we;
            r_width    <= w_sel_width;
            sram_addr  <= word_addr(w_sel_addr[21:0]);
            sram_wdata <= w_lane_wdata;
            sram_be_n  <= w_lane_be_n;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= w_sel_we;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          if (r_we) begin
            sram_we_n    <= 1'b0;
            sram_oe_data <= 1'b1;
          end
        end
        ST_ACCESS: begin
          r_state      <= ST_DONE;
          sram_ce_n    <= 1'b1;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= 1'b1;
          sram_be_n    <= 4'b1111;
          sram_oe_data <= 1'b0;
          if (r_is_if) begin
            if_ack   <= 1'b1;
            if_rdata <= sram_rdata;
          end else begin
            mem_ack <= 1'b1;
            if (!r_we) mem_rdata <= w_lane_rdata;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req, mem_we, mem_byte;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_ack, mem_ack;
  logic [31:0] if_rdata, mem_rdata;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_oe_data, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic        busy;

  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] sram_mem [0:255];

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_oe_data(sram_oe_data), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n), .busy(busy)
  );

  // asynchronous-read SRAM model with per-lane writes at the clock edge
  assign sram_rdata = sram_mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (pl_en) sram_mem[pl_addr] <= pl_data;
    else if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic wait_grant();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("grant_seen", 32'(ok), 32'h1);
  endtask

  task automatic wait_ack(output bit is_mem, output int at);
    bit ok;
    ok = 1'b0;
    is_mem = 1'b0;
    at = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_ack || mem_ack) begin
        ok = 1'b1;
        is_mem = mem_ack;
        at = cyc;
        break;
      end
    end
    chk("ack_seen", 32'(ok), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          m;
    int          t1, t2, g, wl;
    bit          seen;
    logic [31:0] exp_lb [3];
    logic [1:0]  off_lb [3];
    exp_lb = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h0000007F};
    off_lb = '{2'd3, 2'd2, 2'd1};

    rst_n = 1'b0;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_byte = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    poke(8'h04, 32'h12345678);
    poke(8'h08, 32'hCAFEF00D);
    poke(8'h09, 32'h0BADC0DE);
    poke(8'h40, 32'h11223344);
    poke(8'h14, 32'h80FF7F01);
    poke(8'h0C, 32'h55AA55AA);

    // reset state
    chk("rst_ce_n",    32'(sram_ce_n),    32'h1);
    chk("rst_oe_n",    32'(sram_oe_n),    32'h1);
    chk("rst_we_n",    32'(sram_we_n),    32'h1);
    chk("rst_be_n",    32'(sram_be_n),    32'hF);
    chk("rst_oe_data", 32'(sram_oe_data), 32'h0);
    chk("rst_acks",    32'({if_ack, mem_ack}), 32'h0);
    chk("rst_busy",    32'(busy),         32'h0);
    chk("rst_addr",    32'(sram_addr),    32'h0);
    chk("rst_wdata",   sram_wdata,        32'h0);
    chk("rst_if_rd",   if_rdata,          32'h0);
    chk("rst_mem_rd",  mem_rdata,         32'h0);
    rst_n = 1'b1;
    step();

    // single fetch
    if_addr = 32'h10;
    if_req  = 1'b1;
    wait_grant();
    g = cyc;
    chk("f_addr", 32'(sram_addr), 32'h4);
    chk("f_ce_n", 32'(sram_ce_n), 32'h0);
    chk("f_oe_n", 32'(sram_oe_n), 32'h0);
    chk("f_be_n", 32'(sram_be_n), 32'h0);
    step();
    chk("f_ack_early", 32'(if_ack), 32'h0);
    chk("f_we_n", 32'(sram_we_n), 32'h1);
    step();
    chk("f_ack",   32'(if_ack), 32'h1);
    chk("f_lat",   32'(cyc - g), 32'h2);
    chk("f_rdata", if_rdata, 32'h12345678);
    chk("f_no_mack", 32'(mem_ack), 32'h0);
    if_req = 1'b0;
    step();
    chk("f_ack_drop", 32'(if_ack), 32'h0);
    chk("f_idle", 32'(busy), 32'h0);
    chk("f_hold", if_rdata, 32'h12345678);

    // simultaneous requests: mem first, fetch 4 cycles later
    settle();
    if_addr = 32'h24;
    mem_addr = 32'h20; mem_we = 1'b0; mem_byte = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    wait_ack(m, t1);
    chk("sim_first_mem", 32'(m), 32'h1);
    chk("sim_lw_data", mem_rdata, 32'hCAFEF00D);
    mem_req = 1'b0;
    wait_ack(m, t2);
    chk("sim_second_if", 32'(m), 32'h0);
    chk("sim_if_data", if_rdata, 32'h0BADC0DE);
    chk("sim_gap", 32'(t2 - t1), 32'h4);
    if_req = 1'b0;

    // starvation guard: mem held high, grants alternate
    settle();
    if_addr = 32'h10; mem_addr = 32'h20;
    if_req = 1'b1; mem_req = 1'b1;
    t1 = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(m, t2);
      chk("stv_order", 32'(m), (i % 2 == 0) ? 32'h1 : 32'h0);
      if (i > 0) chk("stv_gap", 32'(t2 - t1), 32'h4);
      t1 = t2;
    end
    if_req = 1'b0; mem_req = 1'b0;

    // byte store at 0x103
    settle();
    mem_we = 1'b1; mem_byte = 1'b1; mem_addr = 32'h103; mem_wdata = 32'h000000AB;
    mem_req = 1'b1;
    wait_grant();
    wl = 0;
    wl += (!sram_we_n) ? 1 : 0;
    chk("sb_addr",  32'(sram_addr), 32'h40);
    chk("sb_oe_n",  32'(sram_oe_n), 32'h1);
    step();
    wl += (!sram_we_n) ? 1 : 0;
    chk("sb_be_n",  32'(sram_be_n), 32'h7);
    chk("sb_wdata", sram_wdata, 32'hABABABAB);
    chk("sb_oe_data", 32'(sram_oe_data), 32'h1);
    step();
    wl += (!sram_we_n) ? 1 : 0;
    chk("sb_ack", 32'(mem_ack), 32'h1);
    mem_req = 1'b0;
    step();
    wl += (!sram_we_n) ? 1 : 0;
    chk("sb_we_cycles", 32'(wl), 32'h1);
    chk("sb_mem", sram_mem[8'h40], 32'hAB223344);

    // LB sign extension at offsets 3, 2, 1 of 0x80FF7F01
    for (int i = 0; i < 3; i++) begin
      settle();
      mem_we = 1'b0; mem_byte = 1'b1; mem_addr = {30'h14, off_lb[i]};
      mem_req = 1'b1;
      wait_ack(m, t1);
      chk("lb_is_mem", 32'(m), 32'h1);
      chk("lb_data", mem_rdata, exp_lb[i]);
      mem_req = 1'b0;
    end
    step();
    chk("lb_hold", mem_rdata, 32'h0000007F);
    chk("lb_ack_drop", 32'(mem_ack), 32'h0);

    // reset during ACCESS of a SW
    settle();
    mem_we = 1'b1; mem_byte = 1'b0; mem_addr = 32'h30; mem_wdata = 32'hDEADBEEF;
    mem_req = 1'b1;
    wait_grant();
    step();
    chk("rm_we_low", 32'(sram_we_n), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_we_n",   32'(sram_we_n), 32'h1);
    chk("rm_ce_n",   32'(sram_ce_n), 32'h1);
    chk("rm_be_n",   32'(sram_be_n), 32'hF);
    chk("rm_oe_data", 32'(sram_oe_data), 32'h0);
    chk("rm_busy",   32'(busy), 32'h0);
    mem_req = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      step();
      seen |= mem_ack;
    end
    rst_n = 1'b1;
    repeat (4) begin
      step();
      seen |= mem_ack;
    end
    chk("rm_no_ack", 32'(seen), 32'h0);
    chk("rm_busy_after", 32'(busy), 32'h0);
    chk("rm_no_write", sram_mem[8'h0C], 32'h55AA55AA);
    mem_we = 1'b0;
    mem_req = 1'b1;
    wait_ack(m, t1);
    chk("rm_new_is_mem", 32'(m), 32'h1);
    chk("rm_new_data", mem_rdata, 32'h55AA55AA);
    mem_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  instruction fetch request
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle completion pulse for a fetch
- if_rdata  out  32  fetched word, valid while if_ack=1
- mem_req  in  1  data access request from the MEM stage
- mem_we  in  1  1 = store, 0 = load
- mem_byte  in  1  1 = LB/SB, 0 = LW/SW
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data; byte stores use [7:0]
- mem_ack  out  1  one-cycle completion pulse for a data access
- mem_rdata  out  32  load result, valid while mem_ack=1
- sram_addr  out  20  word address
- sram_wdata  out  32  write data
- sram_rdata  in  32  read data
- sram_oe_data  out  1  data bus drive enable
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  4  byte enables, active low
- busy  out  1  high in any state other than IDLE

Function
REQ-003 The block SHALL share one SRAM port between instruction fetch and data access, using FSM states IDLE, SETUP, ACCESS and DONE.
REQ-004 In IDLE with at least one request pending, the block SHALL grant one requester and latch its address, we, byte and wdata, then move to SETUP; with no request it SHALL stay in IDLE.
REQ-005 Arbitration SHALL give priority to mem_req, except that if_req SHALL win when if_req was pending but denied at the previous grant (starvation guard).
REQ-006 In SETUP, the block SHALL drive sram_ce_n=0, sram_addr = latched address bits [21:2], and sram_be_n; for a read it SHALL also drive sram_oe_n=0.
REQ-007 In ACCESS, a write SHALL drive sram_we_n=0 and sram_oe_data=1, and a read SHALL register sram_rdata at the end of the cycle.
REQ-008 In DONE, the block SHALL assert exactly one of if_ack or mem_ack for one cycle, drive all SRAM strobes inactive, and return to IDLE.
REQ-009 Latency SHALL be as follows: if the grant occurs at edge N, the ack SHALL be high during cycle N+3, and the next grant SHALL be possible at edge N+4.
REQ-010 Word accesses SHALL ignore address bits [1:0] and set sram_be_n=4'b0000.
REQ-011 Byte accesses SHALL clear only the be_n bit addressed by addr[1:0] (0 → bit 0, lowest byte), and byte stores SHALL replicate wdata[7:0] into all four lanes.
REQ-012 LB SHALL return the selected byte sign-extended to 32 bits; for example, byte 0x80 SHALL return 0xFFFFFF80.
REQ-013 Fetches SHALL always be word reads, and a fetch SHALL never write.
REQ-014 A request deasserted after its grant SHALL NOT abort the transaction: the access completes and the ack still pulses.
REQ-015 Requesters SHALL hold req stable until they see their ack, and a req still high in the ack cycle SHALL be treated as a new request.
REQ-016 if_rdata and mem_rdata SHALL hold their last values outside the ack cycle.
REQ-017 The address and data of an in-flight transaction SHALL be unaffected by input changes after the grant.

Reset
REQ-018 On rst_n=0, asynchronously and regardless of state, the block SHALL force: state=IDLE; sram_ce_n, sram_oe_n and sram_we_n to 1; sram_be_n=4'b1111; sram_oe_data=0; if_ack=mem_ack=0; busy=0; starvation flag=0; sram_addr, sram_wdata, if_rdata and mem_rdata to 0.
REQ-019 A reset asserted mid-transaction SHALL drop that transaction, and no ack SHALL be issued for it after reset.

Structure
REQ-020 The FSM state encoding, SRAM_ADDR_W=20, and the load/store width encoding SHALL live in the shared CPU package.
REQ-021 One sub-module, sram_byte_lane, SHALL be purely combinational and SHALL handle be_n generation, write-data replication, and load byte extraction with sign extension.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single fetch: if_req=1, if_addr=0x00000010, SRAM word 4 = 0x12345678 → sram_addr=4; if_ack pulses at cycle N+3 with if_rdata=0x12345678.
- Simultaneous requests: if_req and mem_req (LW at 0x20) asserted together → mem served first; if served next with no idle cycle beyond DONE; the acks are 4 cycles apart.
- Byte store: SB with mem_addr=0x103 and wdata=0x000000AB → sram_be_n=4'b0111 and sram_wdata=0xABABABAB during ACCESS; sram_we_n low for exactly one cycle.
- LB sign extension: word = 0x80FF7F01, address offset 3 → mem_rdata=0xFFFFFF80; offset 2 → 0xFFFFFFFF; offset 1 → 0x0000007F.
- Starvation: mem_req held high continuously while if_req=1 → grants alternate mem, if, mem, if.
- Reset mid-op: rst_n driven low during ACCESS of an SW → strobes go high immediately with no clock edge; no mem_ack is issued; after release, busy=0 and a new request completes normally.
